// File: rtl/systolic_ctrl.sv
// Operand buffers and feed sequencer for an NxN output-stationary systolic multiply grid.
// Optional accumulate-onto-previous-result mode is enabled by defining SYSTOLIC_CTRL_ACCUM_EN.
module systolic_ctrl #(
    parameter int WIDTH = 8,
    parameter int N     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N*N)-1:0] wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   start,
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    input  logic                   acc,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   array_clr,
    output logic [N*WIDTH-1:0]     a_feed,
    output logic [N*WIDTH-1:0]     b_feed
);

    localparam int NE = N * N;
    localparam int KW = $clog2(3 * N);
    localparam logic [KW-1:0] K_FEED_END  = KW'(2 * N - 2);
    localparam logic [KW-1:0] K_DRAIN_END = KW'(3 * N - 3);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t            state, state_d;
    logic [KW-1:0]     k, k_d;
    logic [WIDTH-1:0]  a_buf [NE];
    logic [WIDTH-1:0]  b_buf [NE];
    logic [N*WIDTH-1:0] a_feed_d, b_feed_d;
    logic [N*WIDTH-1:0] a_feed_p1, b_feed_p1;
    logic              wr_ok;
    logic              skip_clear;

`ifdef SYSTOLIC_CTRL_ACCUM_EN
    assign skip_clear = acc;
`else
    assign skip_clear = 1'b0;
`endif

    assign wr_ok = wr_en && (state == IDLE) && (32'(wr_addr) < NE);

    // A write landing on the same edge as the first feed load must be seen by that load.
    function automatic logic [WIDTH-1:0] pick(input logic sel_b, input int idx);
        if (wr_ok && (wr_sel == sel_b) && (32'(wr_addr) == idx))
            return wr_data;
        return sel_b ? b_buf[idx] : a_buf[idx];
    endfunction

    always_comb begin
        state_d = state;
        k_d     = k;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = skip_clear ? FEED : CLEAR;
                    k_d     = '0;
                end
            end
            CLEAR: begin
                state_d = FEED;
                k_d     = '0;
            end
            FEED: begin
                k_d = k + 1'b1;
                if (k == K_FEED_END)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (k == K_DRAIN_END) begin
                    state_d = DONE;
                    k_d     = '0;
                end else begin
                    k_d = k + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                k_d     = '0;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Skewed wavefront: row i / column j lag by i / j steps.
    always_comb begin
        a_feed_d = '0;
        b_feed_d = '0;
        if (state_d == FEED) begin
            for (int i = 0; i < N; i++) begin
                if ((int'(k_d) >= i) && (int'(k_d) - i < N)) begin
                    a_feed_d[i*WIDTH +: WIDTH] = pick(1'b0, i * N + (int'(k_d) - i));
                    b_feed_d[i*WIDTH +: WIDTH] = pick(1'b1, (int'(k_d) - i) * N + i);
                end
            end
        end
    end

    // ---- stage p1: state, step counter, feed registers, buffers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            a_feed_p1 <= '0;
            b_feed_p1 <= '0;
            for (int e = 0; e < NE; e++) begin
                a_buf[e] <= '0;
                b_buf[e] <= '0;
            end
        end else begin
            state     <= state_d;
            k         <= k_d;
            a_feed_p1 <= a_feed_d;
            b_feed_p1 <= b_feed_d;
            if (wr_ok) begin
                if (wr_sel)
                    b_buf[wr_addr] <= wr_data;
                else
                    a_buf[wr_addr] <= wr_data;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign array_clr = (state == CLEAR);
    assign a_feed    = a_feed_p1;
    assign b_feed    = b_feed_p1;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: behavioural run-timeline model plus a simple PE grid driven by the feeds.
module tb_systolic_ctrl;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int NE = N * N;
    localparam int AW = $clog2(N * N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, acc_in = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          busy, done, array_clr;
    logic [N*W-1:0] a_feed, b_feed;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    systolic_ctrl #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start),
`ifdef SYSTOLIC_CTRL_ACCUM_EN
        .acc(acc_in),
`endif
        .busy(busy), .done(done), .array_clr(array_clr), .a_feed(a_feed), .b_feed(b_feed)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // PE grid (output stationary), reset by rst | array_clr
    logic [31:0] gc [N][N];
    logic [W-1:0] ga [N][N];
    logic [W-1:0] gb [N][N];

    function automatic logic [W-1:0] ain(input int i, input int j);
        return (j == 0) ? a_feed[i*W +: W] : ga[i][j-1];
    endfunction
    function automatic logic [W-1:0] bin(input int i, input int j);
        return (i == 0) ? b_feed[j*W +: W] : gb[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (rst || array_clr) begin
                    gc[i][j] <= '0; ga[i][j] <= '0; gb[i][j] <= '0;
                end else begin
                    gc[i][j] <= gc[i][j] + 32'(ain(i, j)) * 32'(bin(i, j));
                    ga[i][j] <= ain(i, j);
                    gb[i][j] <= bin(i, j);
                end
            end
    end

    // Behavioural model: mc counts cycles into a run (0 = idle)
    int          mc = 0;
    bit          macc = 1'b0;
    logic [W-1:0] ma [NE];
    logic [W-1:0] mb [NE];
    logic [31:0] mcx [N][N];

    function automatic int run_len(input bit a);
        return (a ? 0 : 1) + 3 * N - 1;
    endfunction

    function automatic logic [31:0] dot(input int i, input int j);
        logic [31:0] s = 0;
        for (int t = 0; t < N; t++) s += 32'(ma[i*N+t]) * 32'(mb[t*N+j]);
        return s;
    endfunction

    function automatic logic [N*W-1:0] exp_feed(input bit is_b);
        logic [N*W-1:0] r = '0;
        int kk = mc - 1 - (macc ? 0 : 1);
        if (mc != 0 && kk >= 0 && kk <= 2 * N - 2)
            for (int i = 0; i < N; i++) begin
                int d = kk - i;
                if (d >= 0 && d < N) r[i*W +: W] = is_b ? mb[d*N+i] : ma[i*N+d];
            end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mc <= 0;
            macc <= 1'b0;
            for (int e = 0; e < NE; e++) begin ma[e] <= '0; mb[e] <= '0; end
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mcx[i][j] <= '0;
        end else if (mc == 0) begin
            if (wr_en) begin
                if (wr_sel) mb[wr_addr] <= wr_data;
                else        ma[wr_addr] <= wr_data;
            end
            if (start) begin mc <= 1; macc <= acc_in; end
        end else begin
            mc <= (mc == run_len(macc)) ? 0 : mc + 1;
            if (mc == run_len(macc) - 1)
                for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
                    mcx[i][j] <= (macc ? mcx[i][j] : 32'd0) + dot(i, j);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 64'(busy), 64'(mc != 0));
            chk("done", 64'(done), 64'(mc != 0 && mc == run_len(macc)));
            chk("array_clr", 64'(array_clr), 64'(mc == 1 && !macc));
            chk("a_feed", 64'(a_feed), 64'(exp_feed(1'b0)));
            chk("b_feed", 64'(b_feed), 64'(exp_feed(1'b1)));
            if (mc != 0 && mc == run_len(macc))
                for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
                    chk("c_out", 64'(gc[i][j]), 64'(mcx[i][j]));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic sel, input int addr, input int data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = W'(data);
        step();
        wr_en = 1'b0;
    endtask

    task automatic load_base();
        int av[4] = '{1, 2, 3, 4};
        int bv[4] = '{5, 6, 7, 8};
        for (int e = 0; e < 4; e++) begin wr(1'b0, e, av[e]); wr(1'b1, e, bv[e]); end
    endtask

    task automatic start_run(input logic a);
        start = 1'b1; acc_in = a;
        step();
        start = 1'b0; acc_in = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit got = 1'b0;
        for (int n = 0; n < max_cycles && !got; n++) begin
            @(negedge clk);
            got = done;
        end
        chk("done_within_budget", 64'(got), 64'd1);
    endtask

    task automatic chk_c(input string name, input int c00, input int c01, input int c10, input int c11);
        chk({name, "_c00"}, 64'(gc[0][0]), 64'(c00));
        chk({name, "_c01"}, 64'(gc[0][1]), 64'(c01));
        chk({name, "_c10"}, 64'(gc[1][0]), 64'(c10));
        chk({name, "_c11"}, 64'(gc[1][1]), 64'(c11));
    endtask

    initial begin
        int ea0[4] = '{1, 2, 0, 0};
        int ea1[4] = '{0, 3, 4, 0};
        int eb0[4] = '{5, 7, 0, 0};
        int eb1[4] = '{0, 6, 8, 0};
        step(); step();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_feeds", 64'({a_feed, b_feed}), 0);
        mon_en = 1'b1;
        rst = 1'b0;
        step();

        // Basic run with per-step feed and result checks
        load_base();
        start_run(1'b0);
        @(negedge clk);
        chk("s1_clr", 64'(array_clr), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("s1_a_row0", 64'(a_feed[0 +: W]), 64'(ea0[k]));
            chk("s1_a_row1", 64'(a_feed[W +: W]), 64'(ea1[k]));
            chk("s1_b_col0", 64'(b_feed[0 +: W]), 64'(eb0[k]));
            chk("s1_b_col1", 64'(b_feed[W +: W]), 64'(eb1[k]));
            chk("s1_done_early", 64'(done), 0);
        end
        step();
        @(negedge clk);
        chk("s1_done", 64'(done), 1);
        chk_c("s1", 19, 22, 43, 50);
        step();
        @(negedge clk);
        chk("s1_idle_busy", 64'(busy), 0);
        chk_c("s1_persist", 19, 22, 43, 50);

        // Start and writes during busy are ignored
        start_run(1'b0);
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd77;
        step(); step();
        start = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("s3_busy", 64'(busy), 1);
        wait_done(20);
        chk_c("s3", 19, 22, 43, 50);
        step();
        start_run(1'b0);
        wait_done(20);
        chk_c("s3_rerun", 19, 22, 43, 50);
        step();

        // Reset mid-run at k=2, then immediate restart
        start_run(1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("s4_busy", 64'(busy), 0);
        chk("s4_done", 64'(done), 0);
        chk("s4_clr", 64'(array_clr), 0);
        chk("s4_feeds", 64'({a_feed, b_feed}), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("s4_restart_busy", 64'(busy), 1);
        wait_done(20);
        chk_c("s4", 0, 0, 0, 0);
        step();

        // Write and start in the same cycle
        load_base();
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(3); wr_data = 8'd9; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        wait_done(20);
        chk("s5_c11", 64'(gc[1][1]), 90);
        chk("s5_c10", 64'(gc[1][0]), 78);
        step();

`ifdef SYSTOLIC_CTRL_ACCUM_EN
        load_base();
        start_run(1'b0);
        wait_done(20);
        step();
        start_run(1'b1);
        @(negedge clk);
        chk("s6_no_clr", 64'(array_clr), 0);
        for (int n = 0; n < 3; n++) begin
            step();
            @(negedge clk);
            chk("s6_done_early", 64'(done), 0);
        end
        step();
        @(negedge clk);
        chk("s6_done", 64'(done), 1);
        chk_c("s6", 38, 44, 86, 100);
        step();
`endif

        // Randomized traffic; the compare process checks every cycle
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 99);
            if (r < 3) begin
                rst = 1'b1;
            end else begin
                if (r < 50) begin
                    wr_en = 1'b1; wr_sel = 1'($urandom_range(0, 1));
                    wr_addr = AW'($urandom_range(0, NE - 1)); wr_data = W'($urandom);
                end
                if (r % 4 == 0 || r >= 85) begin
                    start = 1'b1;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
                    acc_in = 1'($urandom_range(0, 1));
`endif
                end
            end
            step();
            rst = 1'b0; wr_en = 1'b0; start = 1'b0; acc_in = 1'b0;
        end
        for (int n = 0; n < 30 && busy; n++) step();
        @(negedge clk);
        chk("final_idle", 64'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand bit width, matching the PE grid's operand width.
REQ-002 Parameter N, default 2: systolic array dimension (NxN PEs), legal range 2..8.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  operand buffer write strobe.
REQ-006 wr_sel  input  1  write target: 0 = A buffer, 1 = B buffer.
REQ-007 wr_addr  input  max(1,ceil(log2(N*N)))  element index = row*N + col.
REQ-008 wr_data  input  WIDTH  operand value.
REQ-009 start  input  1  begin one matrix-multiply run.
REQ-010 busy  output  1  high from the start-accepting edge until done deasserts.
REQ-011 done  output  1  single-cycle pulse: array c_out values final.
REQ-012 array_clr  output  1  clears PE accumulators, wired OR'ed with rst into the grid reset.
REQ-013 a_feed  output  N*WIDTH  left-edge row inputs, row i at bits [i*WIDTH +: WIDTH].
REQ-014 b_feed  output  N*WIDTH  top-edge column inputs, column j at bits [j*WIDTH +: WIDTH].

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, DONE, plus step counter k.
REQ-016 In IDLE, a write with wr_en=1 SHALL store wr_data into A[wr_addr] or B[wr_addr] at the clock edge; writes outside IDLE SHALL be ignored.
REQ-017 In IDLE, start=1 SHALL move the FSM to CLEAR, set busy, and hold busy through DONE; start outside IDLE SHALL be ignored.
REQ-018 Write and start in the same IDLE cycle SHALL both take effect, and the run SHALL use the newly written value.
REQ-019 CLEAR SHALL last exactly 1 cycle with array_clr=1, then enter FEED with k=0; array_clr SHALL be 0 in every other state.
REQ-020 During step k, a_feed row i SHALL equal A[i][k-i] when 0 <= k-i < N, otherwise 0.
REQ-021 During step k, b_feed column j SHALL equal B[k-j][j] when 0 <= k-j < N, otherwise 0.
REQ-022 FEED SHALL cover k = 0..2N-2, and DRAIN SHALL cover k = 2N-1..3N-3 with all feeds at 0.
REQ-023 After k=3N-3 the FSM SHALL enter DONE for 1 cycle with done=1, then return to IDLE with busy=0.
REQ-024 a_feed and b_feed SHALL be registered and SHALL be 0 in IDLE, CLEAR and DONE.
REQ-025 The controller SHALL never assert array_clr after DONE, so results persist until the next run's CLEAR.
REQ-026 Buffer contents SHALL persist across runs until overwritten.

Reset
REQ-027 rst=1 SHALL force IDLE, k=0, busy=0, done=0, array_clr=0, feeds=0, and all A/B buffer entries=0.
REQ-028 rst asserted mid-run SHALL abort the run at that edge with no done pulse, and a start on the first cycle after rst deasserts SHALL be accepted.

Configuration
REQ-029 With SYSTOLIC_CTRL_ACCUM_EN defined, the block SHALL add input acc (1 bit); acc=1 sampled with an accepted start SHALL skip CLEAR (IDLE->FEED directly, no array_clr), accumulating onto the existing c_out.
REQ-030 Without SYSTOLIC_CTRL_ACCUM_EN, port acc SHALL be absent and every run SHALL pass through CLEAR.

Verification (N=2, WIDTH=8)
REQ-031 Scenario: write A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> done high 5 edges after the start edge, and the grid c_out = [[19,22],[43,50]].
REQ-032 Scenario: same run, check feeds per step -> a_feed rows (k0..k3) = (1,0),(2,3),(0,4),(0,0); b_feed columns = (5,0),(7,6),(0,8),(0,0).
REQ-033 Scenario: start pulse and a wr_en to A[0] during busy -> run unaffected, A[0] unchanged, busy stays 1 until done.
REQ-034 Scenario: rst at k=2 -> all outputs 0 next cycle, no done pulse; a subsequent start completes normally.
REQ-035 Scenario: wr_en A[3]=9 and start in the same cycle -> c_out[1][1] = 3*6+9*8 = 90.
REQ-036 Scenario (ACCUM_EN): repeat the REQ-031 run with acc=1 -> done 4 edges after start, and c_out = [[38,44],[86,100]].
